// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the dmem_arbiter slice.
// Optional statistics are enabled by defining DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    localparam int unsigned ARB_AW = 8;
    localparam int unsigned ARB_DW = 8;

    typedef enum logic {IDLE, ACCESS} arb_state_t;
    typedef enum logic {PORT_CORE, PORT_HOST} arb_port_t;

    // Command captured in IDLE and replayed to the memory during ACCESS.
    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } arb_cmd_t;

    function automatic arb_port_t pick_winner(input logic c_req, input logic h_req,
                                              input arb_port_t last);
        if (c_req && h_req) begin
            return (last == PORT_HOST) ? PORT_CORE : PORT_HOST;
        end else if (h_req) begin
            return PORT_HOST;
        end
        return PORT_CORE;
    endfunction

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for optional
// arbitration statistics (DMEM_ARB_STATS_EN).
module dmem_arb_sat_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between core and host.
// Define DMEM_ARB_STATS_EN to add conflict_cnt/h_wait_cnt statistics outputs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = ARB_AW,
    parameter int unsigned DW = ARB_DW
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int unsigned CW = 16
`endif
) (
    input  logic          CLK,
    input  logic          start,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CW-1:0] conflict_cnt,
    output logic [CW-1:0] h_wait_cnt
`endif
);

    arb_state_t    state_q, state_d;
    arb_port_t     last_q, last_d;
    arb_cmd_t      cmd_q, cmd_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic          h_rvalid_q, h_rvalid_d;
    arb_port_t     win;
    logic          access;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cmd_d      = cmd_q;
        rdata_d    = rdata_q;
        c_rvalid_d = 1'b0;
        h_rvalid_d = 1'b0;
        win        = pick_winner(c_req, h_req, last_q);
        case (state_q)
            IDLE: begin
                if (c_req || h_req) begin
                    state_d = ACCESS;
                    last_d  = win;
                    if (win == PORT_CORE) begin
                        cmd_d.we    = c_we;
                        cmd_d.addr  = c_addr;
                        cmd_d.wdata = c_wdata;
                    end else begin
                        cmd_d.we    = h_we;
                        cmd_d.addr  = h_addr;
                        cmd_d.wdata = h_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (!cmd_q.we) begin
                    rdata_d    = mem_rdata;
                    c_rvalid_d = (last_q == PORT_CORE);
                    h_rvalid_d = (last_q == PORT_HOST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            state_q    <= IDLE;
            last_q     <= PORT_HOST;
            cmd_q      <= '0;
            rdata_q    <= '0;
            c_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cmd_q      <= cmd_d;
            rdata_q    <= rdata_d;
            c_rvalid_q <= c_rvalid_d;
            h_rvalid_q <= h_rvalid_d;
        end
    end

    // Reset in the ACCESS cycle drops the transaction: no grant, no write strobe.
    assign access    = (state_q == ACCESS) && !start;
    assign c_gnt     = access && (last_q == PORT_CORE);
    assign h_gnt     = access && (last_q == PORT_HOST);
    assign mem_we    = access && cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign rdata     = rdata_q;
    assign c_rvalid  = c_rvalid_q;
    assign h_rvalid  = h_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_sat_cnt #(.CW(CW)) u_conflict_cnt (
        .clk (CLK),
        .clr (start),
        .inc ((state_q == IDLE) && c_req && h_req),
        .cnt (conflict_cnt)
    );

    dmem_arb_sat_cnt #(.CW(CW)) u_h_wait_cnt (
        .clk (CLK),
        .clr (start),
        .inc (h_req && !h_gnt),
        .cnt (h_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural arbitration/memory model feeds
// expectation queues, a negedge monitor checks grants and read returns.
module tb_dmem_arbiter;

    logic       CLK = 1'b0;
    logic       start;
    logic       c_req, c_we, h_req, h_we;
    logic [7:0] c_addr, c_wdata, h_addr, h_wdata;
    logic       c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt, h_wait_cnt;
`endif

    dmem_arbiter #(.AW(8), .DW(8)) dut (
        .CLK(CLK), .start(start),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .h_wait_cnt(h_wait_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Environment memory (data_mem): combinational read, posedge write.
    logic [7:0] mem [256] = '{default: 8'h00};
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct { bit port; bit we; logic [7:0] addr; logic [7:0] wdata; int cyc; } gexp_t;
    typedef struct { bit port; logic [7:0] data; int cyc; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    // Reference model state: memory image, busy slot, last winner, requester agents.
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    bit         m_busy = 0;
    bit         m_win = 0;
    bit         m_last = 1;
    logic [7:0] m_old = 8'h00;
    bit         a_req [2] = '{0, 0};
    bit         a_we [2] = '{0, 0};
    logic [7:0] a_addr [2] = '{8'h00, 8'h00};
    logic [7:0] a_wdata [2] = '{8'h00, 8'h00};

    int gcnt [2] = '{0, 0};
    int last_gnt_cyc = 0;
    int wait_c = 0;
    int wait_h = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        c_req = a_req[0]; c_we = a_we[0]; c_addr = a_addr[0]; c_wdata = a_wdata[0];
        h_req = a_req[1]; h_we = a_we[1]; h_addr = a_addr[1]; h_wdata = a_wdata[1];
    endtask

    task automatic issue(input bit p, input bit we, input logic [7:0] addr, input logic [7:0] wd);
        a_req[p] = 1; a_we[p] = we; a_addr[p] = addr; a_wdata[p] = wd;
    endtask

    // One clock: drive agents, advance the model for the upcoming edge, then wait for it.
    task automatic step(input bit rst);
        bit w;
        gexp_t e;
        start = rst;
        drive();
        if (rst) begin
            if (m_busy) begin
                e = gq.pop_back();
                if (e.we) ref_mem[e.addr] = m_old;
                else void'(rq.pop_back());
                a_req[m_win] = 0;
            end
            m_busy = 0;
            m_last = 1;
        end else if (m_busy) begin
            m_busy = 0;
            a_req[m_win] = 0;
        end else if (a_req[0] || a_req[1]) begin
            w = (a_req[0] && a_req[1]) ? !m_last : a_req[1];
            gq.push_back('{w, a_we[w], a_addr[w], a_wdata[w], cyc + 1});
            m_old = ref_mem[a_addr[w]];
            if (a_we[w]) ref_mem[a_addr[w]] = a_wdata[w];
            else rq.push_back('{w, ref_mem[a_addr[w]], cyc + 2});
            m_busy = 1;
            m_win = w;
            m_last = w;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((a_req[0] || a_req[1] || m_busy) && n < 60) begin
            step(0);
            n++;
        end
        check("drain_bound", 64'(n < 60), 64'd1);
        step(0);
        step(0);
    endtask

    // Monitor: pops expectations whenever the DUT grants or returns read data.
    initial forever begin
        gexp_t ge;
        rexp_t re;
        @(negedge CLK);
        if (c_gnt || h_gnt) begin
            if (gq.size() == 0) begin
                check("unexpected_gnt", {62'd0, h_gnt, c_gnt}, 64'd0);
            end else begin
                ge = gq.pop_front();
                check("gnt", {h_gnt, c_gnt, mem_we, mem_addr, mem_wdata, 16'(cyc)},
                      {ge.port, !ge.port, ge.we, ge.addr, ge.wdata, 16'(ge.cyc)});
                gcnt[h_gnt]++;
                last_gnt_cyc = cyc;
            end
            check("gnt_wait", 64'((h_gnt ? wait_h : wait_c) <= 4), 64'd1);
        end else if (mem_we) begin
            check("mem_we_without_gnt", 64'(mem_we), 64'd0);
        end
        if (c_rvalid || h_rvalid) begin
            if (rq.size() == 0) begin
                check("unexpected_rvalid", {62'd0, h_rvalid, c_rvalid}, 64'd0);
            end else begin
                re = rq.pop_front();
                check("rvalid", {h_rvalid, c_rvalid, rdata, 16'(cyc)},
                      {re.port, !re.port, re.data, 16'(re.cyc)});
            end
        end
        wait_c = (start || c_gnt || !c_req) ? 0 : wait_c + 1;
        wait_h = (start || h_gnt || !h_req) ? 0 : wait_h + 1;
    end

    a_core_hold: assert property (@(posedge CLK) (c_req && !c_gnt && !start) |=> c_req)
        else begin fails++; $display("FAIL core_req_dropped_before_gnt"); end
    a_host_hold: assert property (@(posedge CLK) (h_req && !h_gnt && !start) |=> h_req)
        else begin fails++; $display("FAIL host_req_dropped_before_gnt"); end

    initial begin
        int k0;
        int budget [2];
        int diffs;
        logic [7:0] t2_val [3];
        t2_val = '{8'hFF, 8'hFF, 8'h02};
        start = 1;
        drive();

        // Reset held two cycles with a core write pending.
        issue(0, 1, 8'h00, 8'h55);
        step(1);
        step(1);
        check("rst_outputs", {c_rvalid, h_rvalid, mem_we, rdata, mem_addr, mem_wdata}, 64'd0);
        a_req[0] = 0;
        step(0);
        step(0);
        check("rst_mem0", 64'(mem[0]), 64'h00);

        // Host preload.
        for (int unsigned i = 0; i < 3; i++) begin
            issue(1, 1, 8'(i), t2_val[i]);
            drain();
        end
        for (int unsigned i = 0; i < 3; i++) check("host_write_mem", 64'(mem[i]), 64'(t2_val[i]));

        // Core read of preloaded value.
        issue(0, 0, 8'h02, 8'h00);
        drain();

        // Conflict from reset: core write then host read of the same address.
        step(1);
        issue(0, 1, 8'h04, 8'h7F);
        issue(1, 0, 8'h04, 8'h00);
        drain();
        check("conflict_mem4", 64'(mem[4]), 64'h7F);
`ifdef DMEM_ARB_STATS_EN
        check("conflict_cnt", 64'(conflict_cnt), 64'd1);
        check("h_wait_cnt", 64'(h_wait_cnt), 64'd3);
`endif

        // Both ports saturated: 4 grants each, alternating, within 16 cycles.
        step(1);
        gcnt = '{0, 0};
        budget = '{4, 4};
        k0 = cyc;
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!a_req[p] && budget[p] > 0) begin
                    issue(p[0], 1'($urandom_range(0, 1)), 8'($urandom_range(8, 15)), 8'($urandom));
                    budget[p]--;
                end
            end
            if (budget[0] == 0 && budget[1] == 0 && !a_req[0] && !a_req[1] && !m_busy) break;
            step(0);
        end
        drain();
        check("sat_core_grants", 64'(gcnt[0]), 64'd4);
        check("sat_host_grants", 64'(gcnt[1]), 64'd4);
        check("sat_span", 64'(last_gnt_cyc - k0), 64'd15);

        // Reset during the ACCESS cycle of a core write drops it.
        step(1);
        issue(0, 1, 8'h05, 8'hAA);
        step(0);
        step(1);
        issue(1, 0, 8'h05, 8'h00);
        drain();
        check("rst_access_mem5", 64'(mem[5]), 64'h00);

        // Randomised traffic, including the top address.
        step(1);
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!a_req[p] && $urandom_range(0, 3) != 0) begin
                    issue(p[0], 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                          8'($urandom));
                end
            end
            step(0);
        end
        drain();

        diffs = 0;
        for (int unsigned i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("final_mem_image", 64'(diffs), 64'd0);
        check("gnt_queue_empty", 64'(gq.size()), 64'd0);
        check("rvalid_queue_empty", 64'(rq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
